// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS control unit
//
// Purpose: opcode/funct values, ALU control codes, FSM state encoding and
// datapath mux select codes used by mips_alu_decoder and
// mips_multicycle_control.
// Ports: none (package).

package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  // ALU control codes
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_SUB = 4'd10;

  // FSM state encoding (visible on state_dbg)
  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR = 4'd2;
  localparam logic [3:0] ST_MEM_RD   = 4'd3;
  localparam logic [3:0] ST_MEM_WB   = 4'd4;
  localparam logic [3:0] ST_MEM_WR   = 4'd5;
  localparam logic [3:0] ST_R_EXEC   = 4'd6;
  localparam logic [3:0] ST_R_WB     = 4'd7;
  localparam logic [3:0] ST_I_EXEC   = 4'd8;
  localparam logic [3:0] ST_I_WB     = 4'd9;
  localparam logic [3:0] ST_BRANCH   = 4'd10;
  localparam logic [3:0] ST_JUMP     = 4'd11;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_REG   = 2'd1;
  localparam logic [1:0] SRC_A_SHAMT = 2'd2;

  // ALU operand B select
  localparam logic [1:0] SRC_B_REG     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

endpackage

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - combinational opcode/funct to ALU code and legality decode
//
// Purpose: maps the current instruction to the ALU operation it needs in its
// execute step and flags whether the encoding is supported by this build.
// Ports:
//   opcode   in  6           IR[31:26]
//   funct    in  6           IR[5:0]
//   alu_code out ALU_CTRL_W  ALU operation for the execute step
//   legal    out 1           encoding is supported (honours ENABLE_BNE/ENABLE_J)

module mips_alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter bit ENABLE_BNE = 1'b1,
  parameter bit ENABLE_J   = 1'b1
) (
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  output logic [ALU_CTRL_W-1:0] alu_code,
  output logic                  legal
);

  localparam logic [ALU_CTRL_W-1:0] C_ADD = ALU_CTRL_W'(ALU_ADD);
  localparam logic [ALU_CTRL_W-1:0] C_AND = ALU_CTRL_W'(ALU_AND);
  localparam logic [ALU_CTRL_W-1:0] C_OR  = ALU_CTRL_W'(ALU_OR);
  localparam logic [ALU_CTRL_W-1:0] C_SLL = ALU_CTRL_W'(ALU_SLL);
  localparam logic [ALU_CTRL_W-1:0] C_SUB = ALU_CTRL_W'(ALU_SUB);

  always_comb begin
    alu_code = C_ADD;
    legal    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin alu_code = C_ADD; legal = 1'b1; end
          FN_SUB:  begin alu_code = C_SUB; legal = 1'b1; end
          FN_AND:  begin alu_code = C_AND; legal = 1'b1; end
          FN_OR:   begin alu_code = C_OR;  legal = 1'b1; end
          FN_SLL:  begin alu_code = C_SLL; legal = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      // lw/sw use ADD for the effective address
      OP_ADDI, OP_LW, OP_SW: begin
        alu_code = C_ADD;
        legal    = 1'b1;
      end
      OP_ANDI: begin
        alu_code = C_AND;
        legal    = 1'b1;
      end
      OP_BEQ: begin
        alu_code = C_SUB;
        legal    = 1'b1;
      end
      OP_BNE: begin
        alu_code = C_SUB;
        legal    = ENABLE_BNE;
      end
      OP_J: begin
        alu_code = C_ADD;
        legal    = ENABLE_J;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS control FSM with retired-instruction counter
//
// Purpose: sequences each instruction through fetch, decode, execute, memory
// and writeback, driving every datapath mux select and write enable.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   opcode, funct         instruction register fields
//   zero                  ALU zero flag (branch resolution)
//   mem_ready             memory access completes this cycle
//   mem_read, mem_write   memory strobes; iord selects ALUOut address
//   ir_write, pc_write    IR / PC load enables; pc_src selects PC source
//   alu_src_a, alu_src_b  ALU operand selects; alu_control ALU operation
//   reg_dst, mem_to_reg   register file write address / data selects
//   reg_write             register file write enable
//   instr_done            pulse on the last cycle of a legal instruction
//   illegal_instr         pulse in DECODE for an unsupported encoding
//   instr_count           retired legal instructions (wraps)
//   state_dbg             current FSM state

module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W    = 4,
  parameter int CNT_W         = 32,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ENABLE_BNE    = 1'b1,
  parameter bit ENABLE_J      = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  iord,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  instr_done,
  output logic                  illegal_instr,
  output logic [CNT_W-1:0]      instr_count,
  output logic [3:0]            state_dbg
);

  localparam logic [ALU_CTRL_W-1:0] C_ADD = ALU_CTRL_W'(ALU_ADD);
  localparam logic [ALU_CTRL_W-1:0] C_SUB = ALU_CTRL_W'(ALU_SUB);

  logic [3:0]            state;
  logic [3:0]            next_state;
  logic [ALU_CTRL_W-1:0] dec_alu;
  logic                  dec_legal;
  logic                  ready;

  // Un-gated strobes; reset masks them below so nothing writes while held.
  logic mem_read_s;
  logic mem_write_s;
  logic ir_write_s;
  logic pc_write_s;
  logic reg_write_s;
  logic instr_done_s;
  logic illegal_s;

  // Without a handshake every access completes in its first cycle.
  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  mips_alu_decoder #(
    .ALU_CTRL_W (ALU_CTRL_W),
    .ENABLE_BNE (ENABLE_BNE),
    .ENABLE_J   (ENABLE_J)
  ) u_alu_decoder (
    .opcode   (opcode),
    .funct    (funct),
    .alu_code (dec_alu),
    .legal    (dec_legal)
  );

  always_comb begin
    next_state   = state;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    iord         = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_src       = PC_SRC_ALU;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_REG;
    alu_control  = '0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write_s  = 1'b0;
    instr_done_s = 1'b0;
    illegal_s    = 1'b0;

    case (state)
      ST_FETCH: begin
        // PC+4 is computed every fetch cycle but only committed with the IR.
        mem_read_s  = 1'b1;
        alu_src_b   = SRC_B_FOUR;
        alu_control = C_ADD;
        ir_write_s  = ready;
        pc_write_s  = ready;
        if (ready) next_state = ST_DECODE;
      end

      ST_DECODE: begin
        // Branch target PC + (imm<<2) is precomputed into ALUOut here.
        alu_src_b   = SRC_B_IMM_SH2;
        alu_control = C_ADD;
        if (!dec_legal) begin
          illegal_s  = 1'b1;
          next_state = ST_FETCH;
        end else begin
          case (opcode)
            OP_RTYPE:        next_state = ST_R_EXEC;
            OP_ADDI,OP_ANDI: next_state = ST_I_EXEC;
            OP_LW, OP_SW:    next_state = ST_MEM_ADDR;
            OP_BEQ, OP_BNE:  next_state = ST_BRANCH;
            OP_J:            next_state = ST_JUMP;
            default:         next_state = ST_FETCH;
          endcase
        end
      end

      ST_R_EXEC: begin
        alu_src_a   = (funct == FN_SLL) ? SRC_A_SHAMT : SRC_A_REG;
        alu_src_b   = SRC_B_REG;
        alu_control = dec_alu;
        next_state  = ST_R_WB;
      end

      ST_R_WB: begin
        reg_dst      = 1'b1;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        next_state   = ST_FETCH;
      end

      ST_I_EXEC: begin
        alu_src_a   = SRC_A_REG;
        alu_src_b   = SRC_B_IMM;
        alu_control = dec_alu;
        next_state  = ST_I_WB;
      end

      ST_I_WB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        next_state   = ST_FETCH;
      end

      ST_MEM_ADDR: begin
        alu_src_a   = SRC_A_REG;
        alu_src_b   = SRC_B_IMM;
        alu_control = C_ADD;
        next_state  = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end

      ST_MEM_RD: begin
        iord       = 1'b1;
        mem_read_s = 1'b1;
        if (ready) next_state = ST_MEM_WB;
      end

      ST_MEM_WB: begin
        mem_to_reg   = 1'b1;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        next_state   = ST_FETCH;
      end

      ST_MEM_WR: begin
        // The store retires in the cycle memory accepts it.
        iord         = 1'b1;
        mem_write_s  = 1'b1;
        instr_done_s = ready;
        if (ready) next_state = ST_FETCH;
      end

      ST_BRANCH: begin
        // Only beq and enabled bne reach this state.
        alu_src_a    = SRC_A_REG;
        alu_src_b    = SRC_B_REG;
        alu_control  = C_SUB;
        pc_src       = PC_SRC_ALUOUT;
        pc_write_s   = (opcode == OP_BEQ) ? zero : ~zero;
        instr_done_s = 1'b1;
        next_state   = ST_FETCH;
      end

      ST_JUMP: begin
        pc_src       = PC_SRC_JUMP;
        pc_write_s   = 1'b1;
        instr_done_s = 1'b1;
        next_state   = ST_FETCH;
      end

      default: next_state = ST_FETCH;
    endcase
  end

  assign mem_read      = mem_read_s   & ~reset;
  assign mem_write     = mem_write_s  & ~reset;
  assign ir_write      = ir_write_s   & ~reset;
  assign pc_write      = pc_write_s   & ~reset;
  assign reg_write     = reg_write_s  & ~reset;
  assign instr_done    = instr_done_s & ~reset;
  assign illegal_instr = illegal_s    & ~reset;
  assign state_dbg     = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_FETCH;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (instr_done) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - self-checking bench for mips_multicycle_control

module tb_mips_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [5:0] op_in  [2];
  logic [5:0] fn_in  [2];
  logic       zero_in[2];
  logic       rdy_in [2];

  // DUT a: default build. DUT b: bne/j disabled, 2-bit counter.
  logic        mr_a, mw_a, io_a, irw_a, pcw_a, rd_a, m2r_a, rw_a, dn_a, il_a;
  logic [1:0]  ps_a, sa_a, sb_a;
  logic [3:0]  alu_a, st_a;
  logic [31:0] cnt_a;
  logic        mr_b, mw_b, io_b, irw_b, pcw_b, rd_b, m2r_b, rw_b, dn_b, il_b;
  logic [1:0]  ps_b, sa_b, sb_b;
  logic [3:0]  alu_b, st_b;
  logic [1:0]  cnt_b;

  mips_multicycle_control dut_a (
    .clk(clk), .reset(reset), .opcode(op_in[0]), .funct(fn_in[0]),
    .zero(zero_in[0]), .mem_ready(rdy_in[0]),
    .mem_read(mr_a), .mem_write(mw_a), .iord(io_a), .ir_write(irw_a),
    .pc_write(pcw_a), .pc_src(ps_a), .alu_src_a(sa_a), .alu_src_b(sb_a),
    .alu_control(alu_a), .reg_dst(rd_a), .mem_to_reg(m2r_a), .reg_write(rw_a),
    .instr_done(dn_a), .illegal_instr(il_a), .instr_count(cnt_a), .state_dbg(st_a)
  );

  mips_multicycle_control #(.CNT_W(2), .ENABLE_BNE(1'b0), .ENABLE_J(1'b0)) dut_b (
    .clk(clk), .reset(reset), .opcode(op_in[1]), .funct(fn_in[1]),
    .zero(zero_in[1]), .mem_ready(rdy_in[1]),
    .mem_read(mr_b), .mem_write(mw_b), .iord(io_b), .ir_write(irw_b),
    .pc_write(pcw_b), .pc_src(ps_b), .alu_src_a(sa_b), .alu_src_b(sb_b),
    .alu_control(alu_b), .reg_dst(rd_b), .mem_to_reg(m2r_b), .reg_write(rw_b),
    .instr_done(dn_b), .illegal_instr(il_b), .instr_count(cnt_b), .state_dbg(st_b)
  );

  // Bit 1 = instr_done, bit 19 = mem_read, 16 = ir_write, 15 = pc_write.
  logic [19:0] ctrl_a, ctrl_b;
  assign ctrl_a = {mr_a, mw_a, io_a, irw_a, pcw_a, ps_a, sa_a, sb_a, alu_a,
                   rd_a, m2r_a, rw_a, dn_a, il_a};
  assign ctrl_b = {mr_b, mw_b, io_b, irw_b, pcw_b, ps_b, sa_b, sb_b, alu_b,
                   rd_b, m2r_b, rw_b, dn_b, il_b};

  int errors = 0;
  int checks = 0;
  logic [31:0] cnt_model[2];

  typedef struct {
    int st;
    bit rdy;
  } step_t;
  step_t steps[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit legal_of(int d, logic [5:0] op, logic [5:0] fn);
    bit en = (d == 0);
    case (op)
      6'h00:                      return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h00};
      6'h08, 6'h0C, 6'h23, 6'h2B, 6'h04: return 1'b1;
      6'h05, 6'h02:               return en;
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] r_alu(logic [5:0] fn);
    case (fn)
      6'h20:   return 4'd2;
      6'h22:   return 4'd10;
      6'h24:   return 4'd5;
      6'h25:   return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  // Expected control vector for one cycle spent in phase st.
  function automatic logic [19:0] exp_ctrl(int st, logic [5:0] op, logic [5:0] fn,
                                           logic z, logic rdy, logic legal);
    logic mr, mw, io, irw, pcw, rd, m2r, rw, dn, il;
    logic [1:0] ps, sa, sb;
    logic [3:0] alu;
    {mr, mw, io, irw, pcw, rd, m2r, rw, dn, il} = '0;
    ps = 0; sa = 0; sb = 0; alu = 0;
    case (st)
      0:  begin mr = 1; sb = 1; alu = 2; irw = rdy; pcw = rdy; end
      1:  begin sb = 3; alu = 2; il = ~legal; end
      2:  begin sa = 1; sb = 2; alu = 2; end
      3:  begin io = 1; mr = 1; end
      4:  begin m2r = 1; rw = 1; dn = 1; end
      5:  begin io = 1; mw = 1; dn = rdy; end
      6:  begin sa = (fn == 6'h00) ? 2'd2 : 2'd1; alu = r_alu(fn); end
      7:  begin rd = 1; rw = 1; dn = 1; end
      8:  begin sa = 1; sb = 2; alu = (op == 6'h08) ? 4'd2 : 4'd5; end
      9:  begin rw = 1; dn = 1; end
      10: begin sa = 1; alu = 10; ps = 1; pcw = (op == 6'h04) ? z : ~z; dn = 1; end
      11: begin ps = 2; pcw = 1; dn = 1; end
      default: ;
    endcase
    return {mr, mw, io, irw, pcw, ps, sa, sb, alu, rd, m2r, rw, dn, il};
  endfunction

  // Runs one instruction on DUT d; entered and left ~1 time unit after a rising edge.
  task automatic run_instr(input int d, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int wf, input int wm);
    bit legal;
    logic [19:0] e;
    logic zz;
    legal = legal_of(d, op, fn);
    steps.delete();
    for (int i = 0; i < wf; i++) steps.push_back('{0, 1'b0});
    steps.push_back('{0, 1'b1});
    steps.push_back('{1, 1'($urandom_range(0, 1))});
    if (legal) begin
      case (op)
        6'h00: begin
          steps.push_back('{6, 1'($urandom_range(0, 1))});
          steps.push_back('{7, 1'($urandom_range(0, 1))});
        end
        6'h08, 6'h0C: begin
          steps.push_back('{8, 1'($urandom_range(0, 1))});
          steps.push_back('{9, 1'($urandom_range(0, 1))});
        end
        6'h23: begin
          steps.push_back('{2, 1'($urandom_range(0, 1))});
          for (int i = 0; i < wm; i++) steps.push_back('{3, 1'b0});
          steps.push_back('{3, 1'b1});
          steps.push_back('{4, 1'($urandom_range(0, 1))});
        end
        6'h2B: begin
          steps.push_back('{2, 1'($urandom_range(0, 1))});
          for (int i = 0; i < wm; i++) steps.push_back('{5, 1'b0});
          steps.push_back('{5, 1'b1});
        end
        6'h04, 6'h05: steps.push_back('{10, 1'($urandom_range(0, 1))});
        default:      steps.push_back('{11, 1'($urandom_range(0, 1))});
      endcase
    end
    op_in[d] = op;
    fn_in[d] = fn;
    foreach (steps[k]) begin
      rdy_in[d]  = steps[k].rdy;
      zz         = (steps[k].st == 10) ? z : 1'($urandom_range(0, 1));
      zero_in[d] = zz;
      #1;
      e = exp_ctrl(steps[k].st, op, fn, zz, steps[k].rdy, legal);
      check($sformatf("state[%0d] op%0h", d, op), d ? {28'd0, st_b} : {28'd0, st_a},
            32'(steps[k].st));
      check($sformatf("ctrl[%0d] op%0h st%0d", d, op, steps[k].st),
            d ? {12'd0, ctrl_b} : {12'd0, ctrl_a}, {12'd0, e});
      if (e[1]) cnt_model[d] = (d == 1) ? ((cnt_model[d] + 1) & 32'd3) : cnt_model[d] + 1;
      @(posedge clk);
      #1;
    end
    rdy_in[d] = 1'b0;
    check($sformatf("count[%0d]", d), d ? {30'd0, cnt_b} : cnt_a, cnt_model[d]);
  endtask

  logic [19:0] rst_exp;
  int r;
  logic [5:0] rop, rfn;
  logic [5:0] functs[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00};

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      op_in[d] = 0; fn_in[d] = 0; zero_in[d] = 0; rdy_in[d] = 1'b1;
      cnt_model[d] = 0;
    end
    // Reset state: FETCH selects, every strobe masked even with mem_ready high.
    #12;
    rst_exp = exp_ctrl(0, 6'h00, 6'h00, 1'b0, 1'b1, 1'b1);
    rst_exp[19] = 1'b0; rst_exp[16] = 1'b0; rst_exp[15] = 1'b0;
    check("reset state a", {28'd0, st_a}, 32'd0);
    check("reset count a", cnt_a, 32'd0);
    check("reset ctrl a", {12'd0, ctrl_a}, {12'd0, rst_exp});
    check("reset state b", {28'd0, st_b}, 32'd0);
    check("reset ctrl b", {12'd0, ctrl_b}, {12'd0, rst_exp});
    rdy_in[0] = 1'b0; rdy_in[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases
    run_instr(0, 6'h00, 6'h20, 1'b0, 0, 0);   // add
    run_instr(0, 6'h23, 6'h00, 1'b0, 0, 3);   // lw, 3 wait cycles
    run_instr(0, 6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
    run_instr(0, 6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
    run_instr(0, 6'h05, 6'h00, 1'b0, 1, 0);   // bne taken, fetch wait
    run_instr(0, 6'h02, 6'h00, 1'b0, 0, 0);   // j
    run_instr(0, 6'h00, 6'h3F, 1'b0, 0, 0);   // illegal funct
    run_instr(0, 6'h08, 6'h11, 1'b0, 0, 0);   // addi after illegal
    run_instr(0, 6'h2B, 6'h00, 1'b0, 0, 2);   // sw, 2 wait cycles
    run_instr(1, 6'h05, 6'h00, 1'b0, 0, 0);   // bne disabled -> illegal
    run_instr(1, 6'h02, 6'h00, 1'b0, 0, 0);   // j disabled -> illegal
    for (int i = 0; i < 5; i++) run_instr(1, 6'h08, 6'h00, 1'b0, 0, 0);
    check("wrap count b", {30'd0, cnt_b}, 32'd1);

    // Reset during a store wait: write abandoned, count cleared.
    op_in[0] = 6'h2B; rdy_in[0] = 1'b1;
    @(posedge clk); #1;
    rdy_in[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sw wait state", {28'd0, st_a}, 32'd5);
    check("sw wait mem_write", {31'd0, mw_a}, 32'd1);
    rdy_in[0] = 1'b1;
    reset = 1'b1;
    #1;
    check("rst mem_write", {31'd0, mw_a}, 32'd0);
    check("rst state", {28'd0, st_a}, 32'd0);
    check("rst count", cnt_a, 32'd0);
    check("rst ctrl", {12'd0, ctrl_a}, {12'd0, rst_exp});
    cnt_model[0] = 0; cnt_model[1] = 0;
    @(posedge clk); #1;
    rdy_in[0] = 1'b0;
    reset = 1'b0;
    run_instr(0, 6'h0C, 6'h00, 1'b0, 0, 0);   // andi resumes from FETCH

    // Randomized instruction stream on the default build
    for (int n = 0; n < 60; n++) begin
      r   = $urandom_range(0, 9);
      rfn = 6'($urandom_range(0, 63));
      case (r)
        0: begin rop = 6'h00; rfn = functs[$urandom_range(0, 4)]; end
        1: rop = 6'h08;
        2: rop = 6'h0C;
        3: rop = 6'h23;
        4: rop = 6'h2B;
        5: rop = 6'h04;
        6: rop = 6'h05;
        7: rop = 6'h02;
        8: rop = 6'($urandom_range(0, 63));
        default: rop = 6'h00;
      endcase
      run_instr(0, rop, rfn, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
